repairclk_responder: RTL and testbench

REPAIRCLK_RESPONDER -- requirements
Module: repairclk_responder

---
 rtl/repairclk_responder.sv | 206 ++++++++++++++++++++
 tb/tb_repairclk_responder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/repairclk_responder.sv
`default_nettype none
// ============================================================================
// Module   : repairclk_responder
// Brief    : Responder side of the MBINIT REPAIRCLK handshake. Answers
//            init/result/done requests over the sideband, counts consecutive
//            clean clock-pattern iterations per lane (RCKP, RCKN, RTRK) and
//            reports a sticky per-lane pass vector in result_resp.
// Revision : 1.0 - initial release
// ============================================================================
module repairclk_responder (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       i_MBINIT_CAL_end,
  input  logic [3:0] i_Rx_SbMessage,
  input  logic       i_msg_valid,
  input  logic       i_Busy_SideBand,
  input  logic       i_falling_edge_busy,
  input  logic       i_iter_valid,
  input  logic [2:0] i_iter_ok,
  output logic [3:0] o_TX_SbMessage,
  output logic       o_ValidOutDatat_Module,
  output logic [2:0] o_Clock_track_result_logged,
  output logic       o_Pattern_Detect_En,
  output logic       o_MBINIT_REPAIRCLK_Rx_end
);

  // Sideband message codes
  localparam logic [3:0] INIT_REQ    = 4'b0001;
  localparam logic [3:0] INIT_RESP   = 4'b0010;
  localparam logic [3:0] RESULT_REQ  = 4'b0011;
  localparam logic [3:0] RESULT_RESP = 4'b0100;
  localparam logic [3:0] DONE_REQ    = 4'b0101;
  localparam logic [3:0] DONE_RESP   = 4'b0110;
  localparam logic [3:0] NO_MSG      = 4'b0000;

  // State encoding
  localparam logic [2:0] IDLE             = 3'd0;
  localparam logic [2:0] WAIT_INIT        = 3'd1;
  localparam logic [2:0] SEND_INIT_RESP   = 3'd2;
  localparam logic [2:0] DETECT           = 3'd3;
  localparam logic [2:0] SEND_RESULT_RESP = 3'd4;
  localparam logic [2:0] WAIT_DONE        = 3'd5;
  localparam logic [2:0] SEND_DONE_RESP   = 3'd6;
  localparam logic [2:0] DONE             = 3'd7;

  // Consecutive-match count at which a lane is declared passing
  localparam logic [4:0] PASS_COUNT = 5'd16;
  localparam int         LANES      = 3;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       pending;
  logic       frozen;
  logic [3:0] expect_code;
  logic       req_hit;
  logic       req_ready;
  logic       enter_wait_init;

  logic [4:0] cnt      [LANES];
  logic [4:0] cnt_nxt  [LANES];
  logic [2:0] pass;
  logic [2:0] pass_nxt;

  logic [3:0] tx_msg;
  logic       tx_valid;
  logic [2:0] result;
  logic       detect_en;
  logic       rx_end;

  // Pick the one request each waiting state cares about; anything else is ignored
  always_comb begin
    expect_code = NO_MSG;
    case (state)
      WAIT_INIT: expect_code = INIT_REQ;
      DETECT:    expect_code = RESULT_REQ;
      WAIT_DONE: expect_code = DONE_REQ;
      default:   expect_code = NO_MSG;
    endcase
    req_hit   = i_msg_valid && (expect_code != NO_MSG) && (i_Rx_SbMessage == expect_code);
    // A request seen while the sideband was busy is remembered until it frees up
    req_ready = (req_hit || pending) && !i_Busy_SideBand;
  end

  // Next-state decode; loss of enable overrides every other transition
  always_comb begin
    next_state = state;
    case (state)
      IDLE:             if (i_MBINIT_CAL_end)    next_state = WAIT_INIT;
      WAIT_INIT:        if (req_ready)           next_state = SEND_INIT_RESP;
      SEND_INIT_RESP:   if (i_falling_edge_busy) next_state = DETECT;
      DETECT:           if (req_ready)           next_state = SEND_RESULT_RESP;
      SEND_RESULT_RESP: if (i_falling_edge_busy) next_state = WAIT_DONE;
      WAIT_DONE:        if (req_ready)           next_state = SEND_DONE_RESP;
      SEND_DONE_RESP:   if (i_falling_edge_busy) next_state = DONE;
      DONE:                                      next_state = DONE;
      default:                                   next_state = IDLE;
    endcase
    if (state != IDLE && !i_MBINIT_CAL_end) begin
      next_state = IDLE;
    end
    enter_wait_init = (next_state == WAIT_INIT) && (state != WAIT_INIT);
  end

  // Per-lane consecutive counters and sticky pass bits, advanced only in DETECT
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      cnt_nxt[i]  = cnt[i];
      pass_nxt[i] = pass[i];
      if (state == DETECT && i_iter_valid) begin
        if (i_iter_ok[i]) begin
          cnt_nxt[i] = (cnt[i] == PASS_COUNT) ? PASS_COUNT : cnt[i] + 5'd1;
          if (cnt_nxt[i] == PASS_COUNT) begin
            pass_nxt[i] = 1'b1;
          end
        end else begin
          cnt_nxt[i] = 5'd0;
        end
      end
    end
  end

  // State register and pending-request flag
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) begin
        pending <= 1'b0;
      end else if (req_hit) begin
        pending <= 1'b1;
      end
    end
  end

  // Lane statistics; wiped whenever a new handshake attempt starts
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LANES; i++) cnt[i] <= 5'd0;
      pass <= 3'b000;
    end else if (enter_wait_init) begin
      for (int i = 0; i < LANES; i++) cnt[i] <= 5'd0;
      pass <= 3'b000;
    end else begin
      for (int i = 0; i < LANES; i++) cnt[i] <= cnt_nxt[i];
      pass <= pass_nxt;
    end
  end

  // Reported result tracks the pass bits until result_req, then stays frozen;
  // the freeze cycle still absorbs an iteration landing alongside the request
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      result <= 3'b000;
      frozen <= 1'b0;
    end else if (enter_wait_init) begin
      result <= 3'b000;
      frozen <= 1'b0;
    end else if (state == DETECT && !frozen) begin
      result <= pass_nxt;
      if (req_hit) begin
        frozen <= 1'b1;
      end
    end
  end

  // Outputs registered from the next state so they line up with state entry
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      tx_msg    <= NO_MSG;
      tx_valid  <= 1'b0;
      detect_en <= 1'b0;
      rx_end    <= 1'b0;
    end else begin
      case (next_state)
        SEND_INIT_RESP: begin
          tx_msg   <= INIT_RESP;
          tx_valid <= 1'b1;
        end
        SEND_RESULT_RESP: begin
          tx_msg   <= RESULT_RESP;
          tx_valid <= 1'b1;
        end
        SEND_DONE_RESP: begin
          tx_msg   <= DONE_RESP;
          tx_valid <= 1'b1;
        end
        default: begin
          tx_msg   <= NO_MSG;
          tx_valid <= 1'b0;
        end
      endcase
      detect_en <= (next_state == DETECT);
      rx_end    <= (next_state == DONE);
    end
  end

  assign o_TX_SbMessage              = tx_msg;
  assign o_ValidOutDatat_Module      = tx_valid;
  assign o_Clock_track_result_logged = result;
  assign o_Pattern_Detect_En         = detect_en;
  assign o_MBINIT_REPAIRCLK_Rx_end   = rx_end;

endmodule
`default_nettype wire

// File: tb/tb_repairclk_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_repairclk_responder
// Brief    : Directed self-checking bench for repairclk_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_repairclk_responder;

  localparam logic [3:0] INIT_REQ    = 4'b0001;
  localparam logic [3:0] INIT_RESP   = 4'b0010;
  localparam logic [3:0] RESULT_REQ  = 4'b0011;
  localparam logic [3:0] RESULT_RESP = 4'b0100;
  localparam logic [3:0] DONE_REQ    = 4'b0101;
  localparam logic [3:0] DONE_RESP   = 4'b0110;

  logic       clk;
  logic       rst_n;
  logic       cal_end;
  logic [3:0] rx_msg;
  logic       msg_valid;
  logic       busy;
  logic       fe_busy;
  logic       iter_valid;
  logic [2:0] iter_ok;
  logic [3:0] tx_msg;
  logic       tx_valid;
  logic [2:0] result;
  logic       detect_en;
  logic       rx_end;

  int vectors    = 0;
  int miscompares = 0;

  repairclk_responder dut (
    .CLK                         (clk),
    .rst_n                       (rst_n),
    .i_MBINIT_CAL_end            (cal_end),
    .i_Rx_SbMessage              (rx_msg),
    .i_msg_valid                 (msg_valid),
    .i_Busy_SideBand             (busy),
    .i_falling_edge_busy         (fe_busy),
    .i_iter_valid                (iter_valid),
    .i_iter_ok                   (iter_ok),
    .o_TX_SbMessage              (tx_msg),
    .o_ValidOutDatat_Module      (tx_valid),
    .o_Clock_track_result_logged (result),
    .o_Pattern_Detect_En         (detect_en),
    .o_MBINIT_REPAIRCLK_Rx_end   (rx_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] code);
    msg_valid = 1'b1;
    rx_msg    = code;
    step();
    msg_valid = 1'b0;
    rx_msg    = 4'b0000;
  endtask

  task automatic pulse_fe();
    fe_busy = 1'b1;
    step();
    fe_busy = 1'b0;
  endtask

  task automatic iters(input int n, input logic [2:0] ok);
    for (int k = 0; k < n; k++) begin
      iter_valid = 1'b1;
      iter_ok    = ok;
      step();
    end
    iter_valid = 1'b0;
    iter_ok    = 3'b000;
  endtask

  initial begin
    rst_n      = 1'b0;
    cal_end    = 1'b0;
    rx_msg     = 4'b0000;
    msg_valid  = 1'b0;
    busy       = 1'b0;
    fe_busy    = 1'b0;
    iter_valid = 1'b0;
    iter_ok    = 3'b000;

    // ---- reset state ----
    repeat (3) step();
    check("rst_tx_msg", {4'h0, tx_msg}, 8'h00);
    check("rst_valid",  {7'h0, tx_valid}, 8'h00);
    check("rst_result", {5'h0, result}, 8'h00);
    check("rst_detect", {7'h0, detect_en}, 8'h00);
    check("rst_rx_end", {7'h0, rx_end}, 8'h00);
    rst_n = 1'b1;
    step();

    // ---- nominal handshake, all lanes clean ----
    cal_end = 1'b1;
    step();
    send(INIT_REQ);
    check("nom_init_valid", {7'h0, tx_valid}, 8'h01);
    check("nom_init_code",  {4'h0, tx_msg}, {4'h0, INIT_RESP});
    step();
    check("nom_init_hold",  {7'h0, tx_valid}, 8'h01);
    pulse_fe();
    check("nom_init_drop",  {7'h0, tx_valid}, 8'h00);
    check("nom_detect_en",  {7'h0, detect_en}, 8'h01);
    iters(15, 3'b111);
    check("nom_15_iters",   {5'h0, result}, 8'h00);
    iters(5, 3'b111);
    check("nom_20_iters",   {5'h0, result}, 8'h07);
    send(RESULT_REQ);
    check("nom_res_valid",  {7'h0, tx_valid}, 8'h01);
    check("nom_res_code",   {4'h0, tx_msg}, {4'h0, RESULT_RESP});
    check("nom_res_data",   {5'h0, result}, 8'h07);
    check("nom_res_det_off",{7'h0, detect_en}, 8'h00);
    pulse_fe();
    check("nom_res_drop",   {7'h0, tx_valid}, 8'h00);
    send(DONE_REQ);
    check("nom_done_valid", {7'h0, tx_valid}, 8'h01);
    check("nom_done_code",  {4'h0, tx_msg}, {4'h0, DONE_RESP});
    pulse_fe();
    check("nom_rx_end",     {7'h0, rx_end}, 8'h01);
    check("nom_done_drop",  {7'h0, tx_valid}, 8'h00);
    step();
    check("nom_rx_end_hold",{7'h0, rx_end}, 8'h01);
    check("nom_result_held",{5'h0, result}, 8'h07);
    cal_end = 1'b0;
    step();
    check("nom_exit_rx_end",{7'h0, rx_end}, 8'h00);
    check("nom_idle_result",{5'h0, result}, 8'h07);

    // ---- lane fail: RCKN misses once after 15 clean iterations ----
    cal_end = 1'b1;
    step();
    check("lf_reentry_clear", {5'h0, result}, 8'h00);
    send(INIT_REQ);
    pulse_fe();
    iters(15, 3'b111);
    iters(1, 3'b101);
    check("lf_after_16",    {5'h0, result}, 8'h05);
    iters(10, 3'b111);
    send(RESULT_REQ);
    check("lf_res_code",    {4'h0, tx_msg}, {4'h0, RESULT_RESP});
    check("lf_res_data",    {5'h0, result}, 8'h05);
    pulse_fe();
    cal_end = 1'b0;
    step();

    // ---- busy sideband holds off init_resp ----
    cal_end = 1'b1;
    step();
    busy = 1'b1;
    send(INIT_REQ);
    check("busy_c1_valid",  {7'h0, tx_valid}, 8'h00);
    repeat (4) step();
    check("busy_c5_valid",  {7'h0, tx_valid}, 8'h00);
    busy = 1'b0;
    step();
    check("busy_rel_valid", {7'h0, tx_valid}, 8'h01);
    check("busy_rel_code",  {4'h0, tx_msg}, {4'h0, INIT_RESP});
    repeat (2) step();
    check("busy_hold_valid",{7'h0, tx_valid}, 8'h01);
    pulse_fe();
    check("busy_fe_drop",   {7'h0, tx_valid}, 8'h00);
    check("busy_detect_en", {7'h0, detect_en}, 8'h01);

    // ---- abort during DETECT, then re-entry clears the result ----
    iters(17, 3'b111);
    check("abort_pre_result", {5'h0, result}, 8'h07);
    cal_end = 1'b0;
    step();
    check("abort_detect_off", {7'h0, detect_en}, 8'h00);
    check("abort_valid",      {7'h0, tx_valid}, 8'h00);
    cal_end = 1'b1;
    step();
    check("abort_reentry_res",{5'h0, result}, 8'h00);

    // ---- spurious done_req while waiting for init ----
    send(DONE_REQ);
    check("spur_valid",     {7'h0, tx_valid}, 8'h00);
    check("spur_tx_msg",    {4'h0, tx_msg}, 8'h00);
    check("spur_detect",    {7'h0, detect_en}, 8'h00);
    send(INIT_REQ);
    check("spur_then_init", {4'h0, tx_msg}, {4'h0, INIT_RESP});
    pulse_fe();

    // ---- 16th clean iteration in the same cycle as result_req ----
    iters(15, 3'b111);
    check("race_pre",       {5'h0, result}, 8'h00);
    iter_valid = 1'b1;
    iter_ok    = 3'b111;
    send(RESULT_REQ);
    iter_valid = 1'b0;
    iter_ok    = 3'b000;
    check("race_res_data",  {5'h0, result}, 8'h07);
    check("race_res_code",  {4'h0, tx_msg}, {4'h0, RESULT_RESP});
    iters(3, 3'b000);
    check("race_frozen",    {5'h0, result}, 8'h07);

    // ---- asynchronous reset in the middle of a transmit ----
    check("areset_pre_valid", {7'h0, tx_valid}, 8'h01);
    rst_n = 1'b0;
    #1;
    check("areset_valid",   {7'h0, tx_valid}, 8'h00);
    check("areset_tx_msg",  {4'h0, tx_msg}, 8'h00);
    check("areset_result",  {5'h0, result}, 8'h00);
    step();
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Hard stop in case a step sequence never completes
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
